// File: rtl/deser_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : deser_queue_pkg
//  Brief    : Shared types and default sizes for the serial-to-word queue.
//  Revision : 1.0 - initial release
// ============================================================================
package deser_queue_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH = 8;

    // COLLECT accepts serial bits; WAIT_SPACE parks a finished word until
    // the queue can take it.
    typedef enum logic [0:0] {
        COLLECT    = 1'b0,
        WAIT_SPACE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/deser_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : deser_queue_if
//  Brief    : Serial input, control and queue-status bundle for deser_queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface deser_queue_if
    import deser_queue_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
);
    logic                           data_in;
    logic                           write_in;
    logic                           clear_in;
    logic                           dequeue_in;
    logic                           status_out;
    logic [WIDTH-1:0]               data_out;
    logic [$clog2(DEPTH+1)-1:0]     len_out;
    logic                           empty_out;
    logic                           full_out;
    logic                           overflow_out;

    // Driver side (bit source and consumer)
    modport master (
        output data_in, write_in, clear_in, dequeue_in,
        input  status_out, data_out, len_out, empty_out, full_out, overflow_out
    );

    // Block side
    modport slave (
        input  data_in, write_in, clear_in, dequeue_in,
        output status_out, data_out, len_out, empty_out, full_out, overflow_out
    );
endinterface
`default_nettype wire

// File: rtl/deser_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO, first-word fall-through head, occupancy count.
//             Pop on empty is ignored; push on full only lands with a pop.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    input  wire logic                       i_clear,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [WIDTH-1:0]           i_data,
    output logic      [WIDTH-1:0]           o_head,
    output logic      [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty && !i_clear;
    // A full queue still takes a word when the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop) && !i_clear;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/deser_queue.sv
`default_nettype none
// ============================================================================
//  Module   : deser_queue
//  Brief    : Serial-to-parallel deserializer feeding a word queue. A finished
//             word that cannot enter the queue is held and input stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module deser_queue
    import deser_queue_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter int DEPTH     = c_DEFAULT_DEPTH,
    parameter int MSB_FIRST = 1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    deser_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BIT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_overflow;

    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_push_data;
    logic [WIDTH-1:0]   w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_can_push;
    logic               w_push;
    logic               w_accept;
    logic               w_last_bit;

    // Bit order: MSB-first shifts left so the first bit ends in the top slot.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_shift[WIDTH-2:0], bus.data_in};
        end else begin : g_lsb_first
            assign w_shifted = {bus.data_in, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == CNT_W'(DEPTH));
    assign w_pop      = bus.dequeue_in && !w_empty && !bus.clear_in;
    assign w_can_push = !w_full || w_pop;
    assign w_accept   = (r_state == COLLECT) && bus.write_in;
    assign w_last_bit = w_accept && (r_bit_cnt == BIT_W'(WIDTH-1));

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= COLLECT;
        else       r_state <= w_state_nxt;
    end

    // Next state and push decision; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = w_shifted;
        case (r_state)
            COLLECT: begin
                if (w_last_bit) begin
                    if (w_can_push) w_push      = 1'b1;
                    else            w_state_nxt = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                w_push_data = r_shift;
                if (w_can_push) begin
                    w_push      = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
        if (bus.clear_in) begin
            w_state_nxt = COLLECT;
            w_push      = 1'b0;
        end
    end

    // Shift register, bit counter and sticky overflow. A completed word that
    // cannot be pushed stays in r_shift until WAIT_SPACE releases it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear_in) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= w_shifted;
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
            end
            if ((r_state == WAIT_SPACE) && bus.write_in) r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_clear (bus.clear_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.status_out   = (r_state == COLLECT);
    assign bus.data_out     = w_empty ? '0 : w_head;
    assign bus.len_out      = w_count;
    assign bus.empty_out    = w_empty;
    assign bus.full_out     = w_full;
    assign bus.overflow_out = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_deser_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deser_queue
//  Brief    : Directed self-checking bench, WIDTH=8 DEPTH=4, both bit orders.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_deser_queue;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    deser_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_m ();
    deser_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_l ();

    deser_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) u_dut_msb (
        .clock (clock),
        .reset (reset),
        .bus   (bus_m)
    );

    deser_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) u_dut_lsb (
        .clock (clock),
        .reset (reset),
        .bus   (bus_l)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // pattern[7] goes out first; optional dequeue on the final bit's cycle.
    task automatic send_m(input logic [7:0] pattern, input logic deq_last);
        for (int i = 7; i >= 0; i--) begin
            bus_m.write_in   = 1'b1;
            bus_m.data_in    = pattern[i];
            bus_m.dequeue_in = deq_last && (i == 0);
            tick();
        end
        bus_m.write_in   = 1'b0;
        bus_m.data_in    = 1'b0;
        bus_m.dequeue_in = 1'b0;
    endtask

    task automatic pop_m();
        bus_m.dequeue_in = 1'b1;
        tick();
        bus_m.dequeue_in = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus_m.status_out !== 1'b1) begin n_fail++; $display("FAIL rst_status got %0d exp 1", bus_m.status_out); end
        n_checks++; if (bus_m.data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", bus_m.data_out); end
        n_checks++; if (bus_m.len_out !== 3'd0) begin n_fail++; $display("FAIL rst_len got %0d exp 0", bus_m.len_out); end
        n_checks++; if (bus_m.empty_out !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0d exp 1", bus_m.empty_out); end
        n_checks++; if (bus_m.full_out !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0d exp 0", bus_m.full_out); end
        n_checks++; if (bus_m.overflow_out !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %0d exp 0", bus_m.overflow_out); end
        #10;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_msb_first();
        send_m(8'b1100_0000, 1'b0);
        n_checks++; if (bus_m.len_out !== 3'd1) begin n_fail++; $display("FAIL msb_len got %0d exp 1", bus_m.len_out); end
        n_checks++; if (bus_m.data_out !== 8'hC0) begin n_fail++; $display("FAIL msb_data got %h exp c0", bus_m.data_out); end
        n_checks++; if (bus_m.empty_out !== 1'b0) begin n_fail++; $display("FAIL msb_empty got %0d exp 0", bus_m.empty_out); end
        pop_m();
        n_checks++; if (bus_m.len_out !== 3'd0) begin n_fail++; $display("FAIL msb_pop_len got %0d exp 0", bus_m.len_out); end
        n_checks++; if (bus_m.data_out !== 8'h00) begin n_fail++; $display("FAIL msb_pop_data got %h exp 00", bus_m.data_out); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] pattern;
        pattern = 8'b1100_0000;
        for (int i = 7; i >= 0; i--) begin
            bus_l.write_in = 1'b1;
            bus_l.data_in  = pattern[i];
            tick();
        end
        bus_l.write_in = 1'b0;
        bus_l.data_in  = 1'b0;
        n_checks++; if (bus_l.len_out !== 3'd1) begin n_fail++; $display("FAIL lsb_len got %0d exp 1", bus_l.len_out); end
        n_checks++; if (bus_l.data_out !== 8'h03) begin n_fail++; $display("FAIL lsb_data got %h exp 03", bus_l.data_out); end
    endtask

    task automatic test_underflow();
        pop_m();
        n_checks++; if (bus_m.len_out !== 3'd0) begin n_fail++; $display("FAIL unf_len got %0d exp 0", bus_m.len_out); end
        n_checks++; if (bus_m.empty_out !== 1'b1) begin n_fail++; $display("FAIL unf_empty got %0d exp 1", bus_m.empty_out); end
        n_checks++; if (bus_m.data_out !== 8'h00) begin n_fail++; $display("FAIL unf_data got %h exp 00", bus_m.data_out); end
    endtask

    task automatic test_full_overflow();
        send_m(8'h11, 1'b0);
        send_m(8'h22, 1'b0);
        send_m(8'h33, 1'b0);
        send_m(8'h44, 1'b0);
        n_checks++; if (bus_m.full_out !== 1'b1) begin n_fail++; $display("FAIL full4_full got %0d exp 1", bus_m.full_out); end
        n_checks++; if (bus_m.status_out !== 1'b1) begin n_fail++; $display("FAIL full4_status got %0d exp 1", bus_m.status_out); end
        send_m(8'h55, 1'b0);
        n_checks++; if (bus_m.status_out !== 1'b0) begin n_fail++; $display("FAIL held_status got %0d exp 0", bus_m.status_out); end
        n_checks++; if (bus_m.len_out !== 3'd4) begin n_fail++; $display("FAIL held_len got %0d exp 4", bus_m.len_out); end
        n_checks++; if (bus_m.data_out !== 8'h11) begin n_fail++; $display("FAIL held_head got %h exp 11", bus_m.data_out); end
        n_checks++; if (bus_m.overflow_out !== 1'b0) begin n_fail++; $display("FAIL held_ovf got %0d exp 0", bus_m.overflow_out); end
        bus_m.write_in = 1'b1;
        bus_m.data_in  = 1'b1;
        tick();
        bus_m.write_in = 1'b0;
        bus_m.data_in  = 1'b0;
        n_checks++; if (bus_m.overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0d exp 1", bus_m.overflow_out); end
        pop_m();
        n_checks++; if (bus_m.len_out !== 3'd4) begin n_fail++; $display("FAIL release_len got %0d exp 4", bus_m.len_out); end
        n_checks++; if (bus_m.status_out !== 1'b1) begin n_fail++; $display("FAIL release_status got %0d exp 1", bus_m.status_out); end
        n_checks++; if (bus_m.data_out !== 8'h22) begin n_fail++; $display("FAIL release_head got %h exp 22", bus_m.data_out); end
        pop_m();
        pop_m();
        pop_m();
        n_checks++; if (bus_m.data_out !== 8'h55) begin n_fail++; $display("FAIL fifth_head got %h exp 55", bus_m.data_out); end
        n_checks++; if (bus_m.len_out !== 3'd1) begin n_fail++; $display("FAIL fifth_len got %0d exp 1", bus_m.len_out); end
        n_checks++; if (bus_m.overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0d exp 1", bus_m.overflow_out); end
    endtask

    task automatic test_clear();
        logic [2:0] partial;
        partial = 3'b111;
        send_m(8'h66, 1'b0);
        send_m(8'h77, 1'b0);
        n_checks++; if (bus_m.len_out !== 3'd3) begin n_fail++; $display("FAIL preclr_len got %0d exp 3", bus_m.len_out); end
        for (int i = 2; i >= 0; i--) begin
            bus_m.write_in = 1'b1;
            bus_m.data_in  = partial[i];
            tick();
        end
        bus_m.clear_in   = 1'b1;
        bus_m.dequeue_in = 1'b1;
        bus_m.write_in   = 1'b1;
        bus_m.data_in    = 1'b1;
        tick();
        bus_m.clear_in   = 1'b0;
        bus_m.dequeue_in = 1'b0;
        bus_m.write_in   = 1'b0;
        bus_m.data_in    = 1'b0;
        n_checks++; if (bus_m.len_out !== 3'd0) begin n_fail++; $display("FAIL clr_len got %0d exp 0", bus_m.len_out); end
        n_checks++; if (bus_m.empty_out !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %0d exp 1", bus_m.empty_out); end
        n_checks++; if (bus_m.overflow_out !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %0d exp 0", bus_m.overflow_out); end
        n_checks++; if (bus_m.data_out !== 8'h00) begin n_fail++; $display("FAIL clr_data got %h exp 00", bus_m.data_out); end
        send_m(8'h3C, 1'b0);
        n_checks++; if (bus_m.data_out !== 8'h3C) begin n_fail++; $display("FAIL postclr_data got %h exp 3c", bus_m.data_out); end
        n_checks++; if (bus_m.len_out !== 3'd1) begin n_fail++; $display("FAIL postclr_len got %0d exp 1", bus_m.len_out); end
        pop_m();
    endtask

    task automatic test_reset_midword();
        logic [2:0] partial;
        partial = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            bus_m.write_in = 1'b1;
            bus_m.data_in  = partial[i];
            tick();
        end
        bus_m.write_in = 1'b0;
        bus_m.data_in  = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        send_m(8'hA5, 1'b0);
        n_checks++; if (bus_m.len_out !== 3'd1) begin n_fail++; $display("FAIL rstmid_len got %0d exp 1", bus_m.len_out); end
        n_checks++; if (bus_m.data_out !== 8'hA5) begin n_fail++; $display("FAIL rstmid_data got %h exp a5", bus_m.data_out); end
        pop_m();
        // Reset while a word is held waiting for space.
        send_m(8'h01, 1'b0);
        send_m(8'h02, 1'b0);
        send_m(8'h03, 1'b0);
        send_m(8'h04, 1'b0);
        send_m(8'h05, 1'b0);
        reset = 1'b1;
        #2;
        n_checks++; if (bus_m.status_out !== 1'b1) begin n_fail++; $display("FAIL rstwait_status got %0d exp 1", bus_m.status_out); end
        n_checks++; if (bus_m.full_out !== 1'b0) begin n_fail++; $display("FAIL rstwait_full got %0d exp 0", bus_m.full_out); end
        reset = 1'b0;
        send_m(8'h5A, 1'b0);
        n_checks++; if (bus_m.data_out !== 8'h5A) begin n_fail++; $display("FAIL rstwait_data got %h exp 5a", bus_m.data_out); end
        n_checks++; if (bus_m.len_out !== 3'd1) begin n_fail++; $display("FAIL rstwait_len got %0d exp 1", bus_m.len_out); end
        pop_m();
    endtask

    task automatic test_push_pop_same();
        send_m(8'h10, 1'b0);
        send_m(8'h20, 1'b0);
        n_checks++; if (bus_m.len_out !== 3'd2) begin n_fail++; $display("FAIL pp_pre_len got %0d exp 2", bus_m.len_out); end
        send_m(8'h30, 1'b1);
        n_checks++; if (bus_m.len_out !== 3'd2) begin n_fail++; $display("FAIL pp_len got %0d exp 2", bus_m.len_out); end
        n_checks++; if (bus_m.data_out !== 8'h20) begin n_fail++; $display("FAIL pp_head got %h exp 20", bus_m.data_out); end
        pop_m();
        n_checks++; if (bus_m.data_out !== 8'h30) begin n_fail++; $display("FAIL pp_next got %h exp 30", bus_m.data_out); end
        pop_m();
        n_checks++; if (bus_m.empty_out !== 1'b1) begin n_fail++; $display("FAIL pp_empty got %0d exp 1", bus_m.empty_out); end
        n_checks++; if (bus_m.data_out !== 8'h00) begin n_fail++; $display("FAIL pp_data0 got %h exp 00", bus_m.data_out); end
    endtask

    initial begin
        bus_m.data_in = 1'b0; bus_m.write_in = 1'b0; bus_m.clear_in = 1'b0; bus_m.dequeue_in = 1'b0;
        bus_l.data_in = 1'b0; bus_l.write_in = 1'b0; bus_l.clear_in = 1'b0; bus_l.dequeue_in = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_underflow();
        test_full_overflow();
        test_clear();
        test_reset_midword();
        test_push_pop_same();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
